// File: rtl/mdio_peripheral_if.sv
// MDIO serial pins plus the 32x16 register-file port of the management slave.
// The slave modport is the peripheral's view; master is the controller/memory side.
interface mdio_peripheral_if;
    logic        mdc;
    logic        mdio_out;
    logic        mdio_oe;
    logic        mdio_in;
    logic        mdio_in_oe;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wr_data;
    logic        mem_wr_stb;
    logic        mem_rd_stb;
    logic [15:0] mem_rd_data;
    logic        busy;

    modport slave (
        input  mdc, mdio_out, mdio_oe, mem_rd_data,
        output mdio_in, mdio_in_oe, mem_addr, mem_wr_data, mem_wr_stb, mem_rd_stb, busy
    );

    modport master (
        output mdc, mdio_out, mdio_oe, mem_rd_data,
        input  mdio_in, mdio_in_oe, mem_addr, mem_wr_data, mem_wr_stb, mem_rd_stb, busy
    );
endinterface

// File: rtl/mdio_peripheral.sv
// Clause-22 MDIO slave: decodes frames sampled on mdc rises into register-file strobes.
// Latency: outputs update one clk after each detected mdc rise; no backpressure, the bus is paced by mdc.
module mdio_peripheral #(
    parameter logic [4:0] PHY_ADDR = 5'd1
) (
    input  logic             clk,
    input  logic             reset,
    mdio_peripheral_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ST1, HDR, TA_W, WDATA, TA_R, RDATA, SKIP} state_t;

    state_t      state, state_d;
    logic        mdc_q;
    logic        rise;
    logic [4:0]  cnt, cnt_d;
    logic [10:0] hdr_sh, hdr_d;
    logic [11:0] hdr_new;
    logic [15:0] dat_sh, dat_sh_d;
    logic [15:0] wdat_new;
    logic [4:0]  addr_q, addr_d;
    logic [15:0] wdat_q, wdat_d;
    logic        wr_stb_q, wr_stb_d;
    logic        rd_stb_q, rd_stb_d;
    logic        din_q, din_d;
    logic        din_oe_q, din_oe_d;
    logic        busy_q;

    assign rise = bus.mdc & ~mdc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mdc_q    <= 1'b0;
            cnt      <= '0;
            hdr_sh   <= '0;
            dat_sh   <= '0;
            addr_q   <= '0;
            wdat_q   <= '0;
            wr_stb_q <= 1'b0;
            rd_stb_q <= 1'b0;
            din_q    <= 1'b0;
            din_oe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_d;
            mdc_q    <= bus.mdc;
            cnt      <= cnt_d;
            hdr_sh   <= hdr_d;
            dat_sh   <= dat_sh_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            wr_stb_q <= wr_stb_d;
            rd_stb_q <= rd_stb_d;
            din_q    <= din_d;
            din_oe_q <= din_oe_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        hdr_d    = hdr_sh;
        dat_sh_d = dat_sh;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        wr_stb_d = 1'b0;
        rd_stb_d = 1'b0;
        din_d    = din_q;
        din_oe_d = din_oe_q;
        hdr_new  = {hdr_sh, bus.mdio_out};
        wdat_new = {dat_sh[14:0], bus.mdio_out};

        if (rise) begin
            case (state)
                IDLE: begin
                    if (bus.mdio_oe && !bus.mdio_out) state_d = ST1;
                end
                ST1: begin
                    if (bus.mdio_oe && bus.mdio_out) begin
                        state_d = HDR;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                HDR: begin
                    if (!bus.mdio_oe) begin
                        state_d = IDLE;
                    end else begin
                        hdr_d = hdr_new[10:0];
                        cnt_d = cnt + 5'd1;
                        // hdr_new = {OP[1:0], PHYAD[4:0], REGAD[4:0]} on the last header bit
                        if (cnt == 5'd11) begin
                            if (hdr_new[9:5] != PHY_ADDR || hdr_new[11:10] == 2'b00
                                || hdr_new[11:10] == 2'b11) begin
                                state_d = SKIP;
                                cnt_d   = 5'd18;
                            end else begin
                                addr_d  = hdr_new[4:0];
                                cnt_d   = '0;
                                state_d = (hdr_new[11:10] == 2'b01) ? TA_W : TA_R;
                            end
                        end
                    end
                end
                TA_W: begin
                    if (!bus.mdio_oe) begin
                        state_d = IDLE;
                    end else if (cnt == 5'd1) begin
                        state_d = WDATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 5'd1;
                    end
                end
                WDATA: begin
                    if (!bus.mdio_oe) begin
                        state_d = IDLE;
                    end else begin
                        // shift privately so an aborted frame leaves mem_wr_data untouched
                        dat_sh_d = wdat_new;
                        cnt_d    = cnt + 5'd1;
                        if (cnt == 5'd15) begin
                            wdat_d   = wdat_new;
                            wr_stb_d = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                end
                TA_R: begin
                    if (cnt == 5'd0) begin
                        dat_sh_d = bus.mem_rd_data;
                        rd_stb_d = 1'b1;
                        din_oe_d = 1'b1;
                        din_d    = 1'b0;
                        cnt_d    = 5'd1;
                    end else begin
                        din_d    = dat_sh[15];
                        dat_sh_d = {dat_sh[14:0], 1'b0};
                        cnt_d    = '0;
                        state_d  = RDATA;
                    end
                end
                RDATA: begin
                    if (cnt == 5'd15) begin
                        din_oe_d = 1'b0;
                        din_d    = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        din_d    = dat_sh[15];
                        dat_sh_d = {dat_sh[14:0], 1'b0};
                        cnt_d    = cnt + 5'd1;
                    end
                end
                SKIP: begin
                    cnt_d = cnt - 5'd1;
                    if (cnt == 5'd1) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.mdio_in     = din_q;
    assign bus.mdio_in_oe  = din_oe_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_data = wdat_q;
    assign bus.mem_wr_stb  = wr_stb_q;
    assign bus.mem_rd_stb  = rd_stb_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_mdio_peripheral.sv
// Bench for mdio_peripheral: table of directed frames, hand-written corner sequences,
// and random frames checked against a frame-level register-file model.
module tb_mdio_peripheral;
    localparam logic [4:0] PHY = 5'd1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdio_peripheral_if bus();

    mdio_peripheral #(.PHY_ADDR(PHY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register file seen by the DUT, and the bench's own expectation of its contents.
    logic [15:0] dut_mem [32] = '{default: 16'h0000};
    logic [15:0] ref_mem [32] = '{default: 16'h0000};
    assign bus.mem_rd_data = dut_mem[bus.mem_addr];

    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          oe_cnt = 0;
    logic [4:0]  wr_addr_seen = '0;
    logic [15:0] wr_data_seen = '0;
    logic [4:0]  rd_addr_seen = '0;

    always @(negedge clk) begin
        if (bus.mem_wr_stb) begin
            wr_cnt                <= wr_cnt + 1;
            wr_addr_seen          <= bus.mem_addr;
            wr_data_seen          <= bus.mem_wr_data;
            dut_mem[bus.mem_addr] <= bus.mem_wr_data;
        end
        if (bus.mem_rd_stb) begin
            rd_cnt       <= rd_cnt + 1;
            rd_addr_seen <= bus.mem_addr;
        end
        if (bus.mdio_in_oe) oe_cnt <= oe_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        busy_first;
        logic        ta_in;
        logic        ta_oe;
        logic [15:0] rd_bits;
        logic        end_oe;
        logic        end_busy;
    } obs_t;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic [15:0] data;
        bit          exp_wr;
        bit          exp_rd;
        logic [15:0] exp_rdata;
    } vec_t;

    // One mdc period with random high/low widths; samples DUT outputs one clk after the rise.
    task automatic bit_tx(input logic oe, input logic d, output logic sin, output logic soe,
                          output logic sbusy);
        int lo;
        int hi;
        lo = $urandom_range(1, 3);
        hi = $urandom_range(1, 3);
        bus.mdio_oe  = oe;
        bus.mdio_out = d;
        bus.mdc      = 1'b0;
        repeat (lo) @(negedge clk);
        bus.mdc = 1'b1;
        @(negedge clk);
        sin   = bus.mdio_in;
        soe   = bus.mdio_in_oe;
        sbusy = bus.busy;
        repeat (hi - 1) @(negedge clk);
    endtask

    // Controller side of one frame; releases mdio_oe from TA onwards on reads.
    task automatic send_frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] regad,
                              input logic [15:0] data, input int abort_k, input int stop_k,
                              output obs_t o);
        logic [31:0] f;
        logic        sin, soe, sb, oe_b;
        f = {2'b01, op, phy, regad, 2'b10, data};
        o = '0;
        for (int k = 0; k < stop_k; k++) begin
            oe_b = !((op == 2'b10) && k >= 14) && (k != abort_k);
            bit_tx(oe_b, f[5'(31 - k)], sin, soe, sb);
            if (k == 0) o.busy_first = sb;
            if (k == 14) begin
                o.ta_in = sin;
                o.ta_oe = soe;
            end
            if (k >= 15 && k <= 30) o.rd_bits[4'(30 - k)] = sin;
            o.end_oe   = soe;
            o.end_busy = sb;
            if (k == abort_k) break;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_and_check(input string tag, input logic [1:0] op, input logic [4:0] phy,
                                 input logic [4:0] regad, input logic [15:0] data,
                                 input bit exp_wr, input bit exp_rd, input logic [15:0] exp_rdata);
        int   wr0, rd0, oe0;
        obs_t o;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        oe0 = oe_cnt;
        send_frame(op, phy, regad, data, -1, 32, o);
        check($sformatf("%s.busy_start", tag), 32'(o.busy_first), 32'd1);
        check($sformatf("%s.busy_end", tag), 32'(o.end_busy), 32'd0);
        check($sformatf("%s.wr_stb_count", tag), 32'(wr_cnt - wr0), 32'(exp_wr));
        check($sformatf("%s.rd_stb_count", tag), 32'(rd_cnt - rd0), 32'(exp_rd));
        if (exp_wr) begin
            check($sformatf("%s.wr_addr", tag), 32'(wr_addr_seen), 32'(regad));
            check($sformatf("%s.wr_data", tag), 32'(wr_data_seen), 32'(data));
        end
        if (exp_rd) begin
            check($sformatf("%s.rd_addr", tag), 32'(rd_addr_seen), 32'(regad));
            check($sformatf("%s.ta2_in", tag), 32'(o.ta_in), 32'd0);
            check($sformatf("%s.ta2_oe", tag), 32'(o.ta_oe), 32'd1);
            check($sformatf("%s.rd_bits", tag), 32'(o.rd_bits), 32'(exp_rdata));
            check($sformatf("%s.oe_end", tag), 32'(o.end_oe), 32'd0);
        end else begin
            check($sformatf("%s.no_drive", tag), 32'(oe_cnt - oe0), 32'd0);
        end
    endtask

    vec_t vecs[9];

    initial begin
        obs_t        o;
        logic        sin, soe, sb;
        int          wr0;
        logic [1:0]  op;
        logic [4:0]  phy, regad;
        logic [15:0] data;
        bit          ew, er;

        vecs[0] = '{2'b01, 5'd1, 5'd5,  16'hBEEF, 1'b1, 1'b0, 16'h0000};
        vecs[1] = '{2'b01, 5'd1, 5'd10, 16'hA5C3, 1'b1, 1'b0, 16'h0000};
        vecs[2] = '{2'b10, 5'd1, 5'd10, 16'h0000, 1'b0, 1'b1, 16'hA5C3};
        vecs[3] = '{2'b01, 5'd2, 5'd6,  16'h1234, 1'b0, 1'b0, 16'h0000};
        vecs[4] = '{2'b11, 5'd1, 5'd7,  16'h5555, 1'b0, 1'b0, 16'h0000};
        vecs[5] = '{2'b00, 5'd1, 5'd8,  16'hAAAA, 1'b0, 1'b0, 16'h0000};
        vecs[6] = '{2'b01, 5'd1, 5'd31, 16'hFFFF, 1'b1, 1'b0, 16'h0000};
        vecs[7] = '{2'b10, 5'd1, 5'd31, 16'h0000, 1'b0, 1'b1, 16'hFFFF};
        vecs[8] = '{2'b10, 5'd5, 5'd31, 16'h0000, 1'b0, 1'b0, 16'h0000};

        reset        = 1'b1;
        bus.mdc      = 1'b0;
        bus.mdio_out = 1'b0;
        bus.mdio_oe  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.mdio_in", 32'(bus.mdio_in), 32'd0);
        check("reset.mdio_in_oe", 32'(bus.mdio_in_oe), 32'd0);
        check("reset.mem_addr", 32'(bus.mem_addr), 32'd0);
        check("reset.mem_wr_data", 32'(bus.mem_wr_data), 32'd0);
        check("reset.mem_wr_stb", 32'(bus.mem_wr_stb), 32'd0);
        check("reset.mem_rd_stb", 32'(bus.mem_rd_stb), 32'd0);
        check("reset.busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Directed frames, sent back to back with no idle mdc periods between them.
        for (int i = 0; i < 9; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].phy, vecs[i].regad,
                          vecs[i].data, vecs[i].exp_wr, vecs[i].exp_rd, vecs[i].exp_rdata);
            if (vecs[i].exp_wr) ref_mem[vecs[i].regad] = vecs[i].data;
        end

        // Bad start: "00" enters ST1 then falls back; stray bits in IDLE are ignored.
        bit_tx(1'b1, 1'b0, sin, soe, sb);
        check("badstart.st1_busy", 32'(sb), 32'd1);
        bit_tx(1'b1, 1'b0, sin, soe, sb);
        check("badstart.back_idle", 32'(sb), 32'd0);
        bit_tx(1'b1, 1'b1, sin, soe, sb);
        check("badstart.idle_one", 32'(sb), 32'd0);
        bit_tx(1'b0, 1'b0, sin, soe, sb);
        check("badstart.idle_noe", 32'(sb), 32'd0);
        repeat (2) @(negedge clk);

        // Abort a write after 8 data bits, then a clean write to the same register.
        wr0 = wr_cnt;
        send_frame(2'b01, PHY, 5'd3, 16'hC3C3, 24, 32, o);
        check("abort.busy", 32'(o.end_busy), 32'd0);
        check("abort.no_wr", 32'(wr_cnt - wr0), 32'd0);
        run_and_check("after_abort", 2'b01, PHY, 5'd3, 16'h0001, 1'b1, 1'b0, 16'h0000);
        ref_mem[3] = 16'h0001;

        // Reset in the middle of read data: outputs clear without a clk edge.
        send_frame(2'b10, PHY, 5'd10, 16'h0000, -1, 21, o);
        check("midread.oe_before", 32'(o.end_oe), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midread.oe_async", 32'(bus.mdio_in_oe), 32'd0);
        check("midread.busy_async", 32'(bus.busy), 32'd0);
        check("midread.mdio_in_async", 32'(bus.mdio_in), 32'd0);
        check("midread.addr_async", 32'(bus.mem_addr), 32'd0);
        @(negedge clk);
        bus.mdc     = 1'b0;
        bus.mdio_oe = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Random frames against the register-file model.
        for (int i = 0; i < 40; i++) begin
            op    = 2'($urandom_range(0, 3));
            phy   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : PHY;
            regad = 5'($urandom_range(0, 31));
            data  = 16'($urandom);
            ew    = (phy == PHY) && (op == 2'b01);
            er    = (phy == PHY) && (op == 2'b10);
            run_and_check($sformatf("rnd%0d", i), op, phy, regad, data, ew, er, ref_mem[regad]);
            if (ew) ref_mem[regad] = data;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
